// File: rtl/normalizer.sv
// Iterative normalizer: shifts a signed accumulator left one bit per cycle until the sign bit is significant.
// Optional build macro NORMALIZER_ROUND_EN adds round-half-up with positive saturation on the extracted mantissa.
module normalizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    localparam int SW       = $clog2(OUT_WIDTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [IN_WIDTH-1:0]  acc,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] mant,
    output logic        [SW-1:0]        sh,
    output logic                        out_valid,
    input  logic                        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SW-1:0] C_MAX = SW'(OUT_WIDTH - 1);

    state_t                       state;
    state_t                       state_next;
    logic signed [IN_WIDTH-1:0]   w;
    logic        [SW-1:0]         c;
    logic                         can_shift;
    logic signed [OUT_WIDTH-1:0]  mant_next;

`ifdef NORMALIZER_ROUND_EN
    localparam logic signed [OUT_WIDTH-1:0] MANT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    // Only the largest positive mantissa can overflow; negative values round toward zero safely.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(
        input logic signed [OUT_WIDTH-1:0] top,
        input logic                        half
    );
        if (half && (top == MANT_MAX))
            return MANT_MAX;
        return top + {{(OUT_WIDTH-1){1'b0}}, half};
    endfunction

    assign mant_next = round_sat(w[IN_WIDTH-1 -: OUT_WIDTH], w[IN_WIDTH-OUT_WIDTH-1]);
`else
    assign mant_next = w[IN_WIDTH-1 -: OUT_WIDTH];
`endif

    assign can_shift = (w[IN_WIDTH-1] == w[IN_WIDTH-2]) && (c < C_MAX);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (!can_shift)
                    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w    <= '0;
            c    <= '0;
            mant <= '0;
            sh   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        w <= acc;
                        c <= '0;
                    end
                end
                SHIFT: begin
                    if (can_shift) begin
                        w <= w << 1;
                        c <= c + 1'b1;
                    end else begin
                        mant <= mant_next;
                        sh   <= c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: driver queues expected results, monitor checks each out_valid rise.
module tb_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] acc;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mant;
    logic [3:0]  sh;
    logic        out_valid;
    logic        out_ready;

    normalizer dut (
        .clk       (clk),
        .reset     (reset),
        .acc       (acc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant      (mant),
        .sh        (sh),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mant;
        logic [3:0]  sh;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: one scoreboard entry per rising out_valid.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && !ov_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mant", 32'(mant), 32'(e.mant));
                check("sh", 32'(sh), 32'(e.sh));
                check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
        end
        ov_prev = (out_valid === 1'b1);
    end

    task automatic issue(input logic [31:0] a, input logic [15:0] em, input logic [3:0] es,
                         input bit push);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        acc      = a;
        in_valid = 1'b1;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        if (push) sb.push_back('{em, es, int'(es) + 1});
    endtask

    task automatic finish_op(input logic [15:0] em, input logic [3:0] es, input bit hold);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                acc      = 32'h1234_5678;
                in_valid = 1'b1;
                @(negedge clk);
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_mant", 32'(mant), 32'(em));
                check("hold_sh", 32'(sh), 32'(es));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (hold) begin
            check("release_out_valid", 32'(out_valid), 32'd0);
            check("release_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] m4000;
        logic [15:0] mffff;
        int n;
`ifdef NORMALIZER_ROUND_EN
        m4000 = 16'h4001;
        mffff = 16'h0000;
`else
        m4000 = 16'h4000;
        mffff = 16'hFFFF;
`endif
        reset     = 1'b1;
        acc       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mant", 32'(mant), 32'd0);
        check("rst_sh", 32'(sh), 32'd0);
        out_ready = 1'b0;

        issue(32'h0001_2345, 16'h48D1, 4'hE, 1'b1);
        finish_op(16'h48D1, 4'hE, 1'b0);

        // Reset five edges after accept abandons the operation.
        issue(32'h0001_2345, 16'h0000, 4'h0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_mant", 32'(mant), 32'd0);
        check("midrst_sh", 32'(sh), 32'd0);
        repeat (20) @(negedge clk);

        issue(32'hFFFF_8000, 16'hC000, 4'hF, 1'b1);
        finish_op(16'hC000, 4'hF, 1'b0);
        issue(32'h4000_8000, m4000, 4'h0, 1'b1);
        finish_op(m4000, 4'h0, 1'b0);
        issue(32'h7FFF_C000, 16'h7FFF, 4'h0, 1'b1);
        finish_op(16'h7FFF, 4'h0, 1'b0);
        issue(32'h0000_0000, 16'h0000, 4'hF, 1'b1);
        finish_op(16'h0000, 4'hF, 1'b0);
        issue(32'hFFFF_FFFF, mffff, 4'hF, 1'b1);
        finish_op(mffff, 4'hF, 1'b0);

        // Hold the result, with a stray in_valid that must be ignored.
        issue(32'h0001_2345, 16'h48D1, 4'hE, 1'b1);
        finish_op(16'h48D1, 4'hE, 1'b1);
        repeat (20) @(negedge clk);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
